// File: rtl/bcd_digit_formatter.sv
// Binary-to-BCD formatter: a 16-bit value becomes five display digits through
// 16 serial double-dabble steps. Leading zeros are optionally blanked to 4'hF.
module bcd_digit_formatter #(
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic [3:0]  dig4,
    output logic [3:0]  dig3,
    output logic [3:0]  dig2,
    output logic [3:0]  dig1,
    output logic [3:0]  dig0,
    output logic        out_valid,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FMT  = 2'd2
    } state_t;

    state_t      state_reg;
    logic [15:0] shift_reg;
    logic [19:0] bcd_reg;
    logic [4:0]  count_reg;
    logic [3:0]  dig_reg [5];
    logic        out_valid_reg;
    logic        in_ready_reg;

    logic [19:0] bcd_adj_next;
    logic [4:1]  zero_next;
    logic [4:0]  blank_next;
    logic [3:0]  dig_next [5];

    genvar gi;

    // Per-nibble +3 correction ahead of the shift; keeps every nibble in 0..9.
    generate
        for (gi = 0; gi < 5; gi++) begin : g_adj
            assign bcd_adj_next[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                             bcd_reg[gi*4 +: 4] + 4'd3 :
                                             bcd_reg[gi*4 +: 4];
            assign dig_next[gi] = blank_next[gi] ? 4'hF : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    // A digit is blanked only if it and every more-significant digit are zero.
    generate
        for (gi = 1; gi < 5; gi++) begin : g_blank
            assign zero_next[gi] = (bcd_reg[gi*4 +: 4] == 4'd0);
            if (gi == 4) begin : g_top
                assign blank_next[gi] = BLANK_LEADING && zero_next[gi];
            end else begin : g_lower
                assign blank_next[gi] = blank_next[gi+1] && zero_next[gi];
            end
        end
    endgenerate

    assign blank_next[0] = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            bcd_reg       <= '0;
            count_reg     <= '0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            for (int i = 0; i < 5; i++) begin
                dig_reg[i] <= 4'hF;
            end
        end else begin
            out_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        shift_reg    <= in_data;
                        bcd_reg      <= '0;
                        count_reg    <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= CONV;
                    end
                end
                CONV: begin
                    shift_reg <= shift_reg << 1;
                    bcd_reg   <= (bcd_adj_next << 1) | {19'd0, shift_reg[15]};
                    count_reg <= count_reg + 5'd1;
                    if (count_reg == 5'd15) begin
                        state_reg <= FMT;
                    end
                end
                FMT: begin
                    for (int i = 0; i < 5; i++) begin
                        dig_reg[i] <= dig_next[i];
                    end
                    out_valid_reg <= 1'b1;
                    in_ready_reg  <= 1'b1;
                    state_reg     <= IDLE;
                end
                default: begin
                    in_ready_reg <= 1'b1;
                    state_reg    <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign busy      = ~in_ready_reg;
    assign out_valid = out_valid_reg;
    assign dig4      = dig_reg[4];
    assign dig3      = dig_reg[3];
    assign dig2      = dig_reg[2];
    assign dig1      = dig_reg[1];
    assign dig0      = dig_reg[0];

endmodule

// File: tb/tb_bcd_digit_formatter.sv
// Scoreboard bench for bcd_digit_formatter: two instances (blanking on/off)
// share stimulus; a monitor checks results, latency, handshake and hold.
module tb_bcd_digit_formatter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;

    logic        rdy [2];
    logic        bsy [2];
    logic        ov  [2];
    logic [3:0]  d4 [2], d3 [2], d2 [2], d1 [2], d0 [2];
    logic [19:0] act [2];

    typedef struct {
        logic [15:0] v;
        logic [19:0] d;
        int          cyc;
    } exp_t;

    exp_t        qs [2][$];
    logic [19:0] last_exp [2];
    int          cyc = 0;
    int          exp_ready_cyc = 0;
    int          tests = 0;
    int          fails = 0;

    bcd_digit_formatter #(.BLANK_LEADING(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy[0]), .dig4(d4[0]), .dig3(d3[0]), .dig2(d2[0]),
        .dig1(d1[0]), .dig0(d0[0]), .out_valid(ov[0]), .busy(bsy[0])
    );

    bcd_digit_formatter #(.BLANK_LEADING(1'b0)) u_dut_plain (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy[1]), .dig4(d4[1]), .dig3(d3[1]), .dig2(d2[1]),
        .dig1(d1[1]), .dig0(d0[1]), .out_valid(ov[1]), .busy(bsy[1])
    );

    assign act[0] = {d4[0], d3[0], d2[0], d1[0], d0[0]};
    assign act[1] = {d4[1], d3[1], d2[1], d1[1], d0[1]};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, a, e);
        end
    endtask

    // Decimal digits by division, then leading-zero blanking on positions 4..1.
    function automatic logic [19:0] ref_digits(input int v, input bit blank);
        logic [19:0] r;
        bit lead;
        int p;
        int d;
        r = '0;
        lead = blank;
        for (int i = 4; i >= 0; i--) begin
            p = 1;
            for (int j = 0; j < i; j++) p = p * 10;
            d = (v / p) % 10;
            if (lead && i > 0 && d == 0) begin
                r[i*4 +: 4] = 4'hF;
            end else begin
                lead = 1'b0;
                r[i*4 +: 4] = 4'(d);
            end
        end
        return r;
    endfunction

    // Called at negedge+1: waits for in_ready, predicts result for both DUTs.
    task automatic issue(input logic [15:0] v);
        int t;
        exp_t e;
        t = 0;
        in_valid = 1'b1;
        in_data  = v;
        while (!rdy[0] && t < 40) begin
            @(negedge clk); #1;
            t++;
        end
        check("accept_timeout", 32'(rdy[0]), 32'd1);
        if (rdy[0]) begin
            e.v = v;
            e.cyc = cyc + 18;
            e.d = ref_digits(int'(v), 1'b1);
            qs[0].push_back(e);
            e.d = ref_digits(int'(v), 1'b0);
            qs[1].push_back(e);
            exp_ready_cyc = cyc + 18;
        end
        @(negedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_data = 16'($urandom);
            @(negedge clk); #1;
        end
    endtask

    task automatic check_reset_outputs();
        for (int k = 0; k < 2; k++) begin
            check("rst_in_ready", 32'(rdy[k]), 32'd1);
            check("rst_busy", 32'(bsy[k]), 32'd0);
            check("rst_out_valid", 32'(ov[k]), 32'd0);
            check("rst_digits", 32'(act[k]), 32'hFFFFF);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check_reset_outputs();
        qs[0].delete();
        qs[1].delete();
        last_exp[0] = 20'hFFFFF;
        last_exp[1] = 20'hFFFFF;
        exp_ready_cyc = 0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk); #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            check("in_ready", 32'(rdy[k]), 32'(cyc >= exp_ready_cyc));
            check("busy", 32'(bsy[k]), 32'(cyc < exp_ready_cyc));
            if (ov[k]) begin
                if (qs[k].size() == 0) begin
                    check("unexpected_out", 32'(ov[k]), 32'd0);
                end else begin
                    e = qs[k].pop_front();
                    check("digits", 32'(act[k]), 32'(e.d));
                    check("latency", cyc, e.cyc);
                    last_exp[k] = e.d;
                    $display("[TB] dut%0d in=%0d digits=%05h expected=%05h cycle=%0d",
                             k, e.v, act[k], e.d, cyc);
                end
            end else begin
                check("hold", 32'(act[k]), 32'(last_exp[k]));
                if (qs[k].size() > 0 && cyc > qs[k][0].cyc) begin
                    check("missing_out", 32'(ov[k]), 32'd1);
                    void'(qs[k].pop_front());
                end
            end
        end
    end

    initial begin
        int t;
        last_exp[0] = 20'hFFFFF;
        last_exp[1] = 20'hFFFFF;
        #1 rst_n = 1'b0;
        #2 check_reset_outputs();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk); #1;

        issue(16'd0);
        idle(2);
        issue(16'd1234);
        issue(16'd10000);
        issue(16'd65535);
        idle(1);
        issue(16'd905);
        issue(16'd42);
        idle(3);
        issue(16'd7);
        issue(16'd8);
        idle(1);
        foreach (qs[0][i]) begin end
        issue(16'd9);
        issue(16'd10);
        issue(16'd99);
        issue(16'd100);
        issue(16'd1000);
        idle(2);

        // Abort a conversion partway through; nothing may come out of it.
        issue(16'd4321);
        repeat (8) @(negedge clk);
        #2;
        apply_reset();
        idle(20);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: issue(16'($urandom_range(0, 99)));
                1: issue(16'($urandom_range(100, 9999)));
                default: issue(16'($urandom));
            endcase
            idle(int'($urandom_range(0, 2)));
        end

        t = 0;
        while ((qs[0].size() + qs[1].size()) > 0 && t < 60) begin
            @(negedge clk); #1;
            t++;
        end
        check("drain", qs[0].size() + qs[1].size(), 32'd0);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
